// File: rtl/sum_match_pkg.sv
// sum_match_pkg
//   Shared definitions for the sum-match scanner: the scan FSM state
//   encoding and the default key width / table depth.
package sum_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int W_DEFAULT = 4;
  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/sum_eq_compare.sv
// sum_eq_compare
//   Combinational test of K == (A + B) mod 2^W without forming the sum.
//   For each bit, the carry that K would need out of that position
//   (creq) is derived from a, b and k alone; K matches when every sum
//   bit a^b^k agrees with the carry required from the position below.
// Ports:
//   a, b : W-bit operands
//   k    : W-bit candidate key
//   eq   : 1 when k equals the wrapped sum of a and b
module sum_eq_compare #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] k,
  output logic         eq
);

  logic [W-1:0] creq;
  logic [W-1:0] cin;

  assign creq = ((a ^ b) & ~k) | (a & b);
  // Carry into bit 0 is zero; the top carry-out falls off (wrap-around).
  assign cin  = creq << 1'b1;
  assign eq   = ((a ^ b ^ k) == cin);

endmodule

// File: rtl/sum_match_scanner.sv
// sum_match_scanner
//   Holds N keys with valid bits and answers lookups of the form
//   "which lowest valid entry equals (A + B) mod 2^W". One entry is
//   checked per cycle through a single shared comparator.
//   Optional feature: define SUM_MATCH_EARLY_EXIT_EN to leave the scan on
//   the first hit; otherwise every lookup scans all N entries.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en/wr_idx/wr_key : table write (sets the entry's valid bit)
//   clr_all             : invalidate all entries (beats a same-cycle write)
//   req_valid/req_ready : request handshake, operands req_a / req_b
//   rsp_valid/rsp_ready : response handshake, result rsp_hit / rsp_idx
module sum_match_scanner
  import sum_match_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int N  = N_DEFAULT,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_key,
  input  logic          clr_all,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic [IW-1:0] rsp_idx
);

`ifdef SUM_MATCH_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  keys [N];
  logic [N-1:0]  valid;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [IW-1:0] scan_idx;
  logic          hit;
  logic [IW-1:0] found_idx;
  logic          eq;
  logic          match;
  logic          accept;

  // Requests are taken only while req_ready is shown, so the cycle just
  // after reset (req_ready low, state IDLE) cannot accept.
  assign accept = req_valid & req_ready;

  sum_eq_compare #(.W(W)) u_cmp (
    .a  (op_a),
    .b  (op_b),
    .k  (keys[scan_idx]),
    .eq (eq)
  );

  assign match = eq & valid[scan_idx];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        if ((scan_idx == LAST_IDX) || (EARLY_EXIT && match)) begin
          state_next = RESP;
        end else begin
          state_next = SCAN;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    rsp_valid = 1'b0;
    case (state)
      RESP:    rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // req_ready is registered from the next state so it is low while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
    end
  end

  // Operand latch, scan pointer and first-hit capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= {W{1'b0}};
      op_b      <= {W{1'b0}};
      scan_idx  <= {IW{1'b0}};
      hit       <= 1'b0;
      found_idx <= {IW{1'b0}};
    end else if (accept) begin
      op_a      <= req_a;
      op_b      <= req_b;
      scan_idx  <= {IW{1'b0}};
      hit       <= 1'b0;
      found_idx <= {IW{1'b0}};
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + IDX_ONE;
      // Scan runs low to high, so the first hit is the lowest index.
      if (match && !hit) begin
        hit       <= 1'b1;
        found_idx <= scan_idx;
      end else begin
        hit       <= hit;
        found_idx <= found_idx;
      end
    end else begin
      scan_idx <= scan_idx;
    end
  end

  // Key table and valid bits; clr_all takes priority over a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        keys[i] <= {W{1'b0}};
      end
    end else if (clr_all) begin
      valid <= {N{1'b0}};
    end else if (wr_en) begin
      keys[wr_idx]  <= wr_key;
      valid[wr_idx] <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  assign rsp_hit = hit;
  assign rsp_idx = found_idx;

endmodule

// File: tb/tb_sum_match_scanner.sv
// tb_sum_match_scanner
//   Directed self-checking bench for sum_match_scanner (W=4, N=8).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Cycle 0 is the cycle in which req_valid is presented with req_ready high.
module tb_sum_match_scanner;

  localparam int W  = 4;
  localparam int N  = 8;
  localparam int IW = 3;

`ifdef SUM_MATCH_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_key;
  logic          clr_all;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [IW-1:0] rsp_idx;

  int checks = 0;
  int errors = 0;

  sum_match_scanner #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_key    (wr_key),
    .clr_all   (clr_all),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [IW-1:0] idx, input logic [W-1:0] key);
    wr_en  = 1'b1;
    wr_idx = idx;
    wr_key = key;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic clear_table();
    clr_all = 1'b1;
    @(negedge clk);
    clr_all = 1'b0;
  endtask

  // Waits for rsp_valid starting in cycle start_cyc; returns the cycle seen.
  task automatic wait_rsp(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy_rise"}, 32'(req_ready), 32'd1);
  endtask

  task automatic lookup(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic exp_hit, input logic [IW-1:0] exp_idx, input int exp_cyc);
    int cyc;
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(1, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
    chk({tag, "_idx"}, 32'(rsp_idx), 32'(exp_idx));
    finish_rsp(tag);
  endtask

  initial begin
    int cyc;
    logic seen;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_idx    = 3'd0;
    wr_key    = 4'd0;
    clr_all   = 1'b0;
    req_valid = 1'b0;
    req_a     = 4'd0;
    req_b     = 4'd0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rvld",  32'(rsp_valid), 32'd0);
    chk("rst_hit",   32'(rsp_hit),   32'd0);
    chk("rst_idx",   32'(rsp_idx),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic match: 3 + 4 = 7 at entry 3
    wr(3'd3, 4'h7);
    lookup("match", 4'h3, 4'h4, 1'b1, 3'd3, EE ? 5 : N + 1);

    // Wrap-around: 0xF + 0x2 = 0x1 at entry 0
    wr(3'd0, 4'h1);
    lookup("wrap", 4'hF, 4'h2, 1'b1, 3'd0, EE ? 2 : N + 1);

    // All entries 0x5 then cleared; a clr_all beats a same-cycle write
    for (int i = 0; i < N; i++) wr(3'(i), 4'h5);
    clear_table();
    clr_all = 1'b1;
    wr(3'd1, 4'h5);
    clr_all = 1'b0;
    lookup("miss", 4'h2, 4'h3, 1'b0, 3'd0, N + 1);

    // Two matching entries: lowest wins
    wr(3'd2, 4'hA);
    wr(3'd6, 4'hA);
    lookup("multi", 4'h8, 4'h2, 1'b1, 3'd2, EE ? 4 : N + 1);

    // Backpressure: hold the response, new requests ignored
    chk("bp_rdy0", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = 4'h8;
    req_b     = 4'h2;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(1, cyc);
    chk("bp_lat", 32'(cyc), EE ? 32'd4 : 32'(N + 1));
    req_valid = 1'b1;
    req_a     = 4'h0;
    req_b     = 4'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld",  32'(rsp_valid), 32'd1);
      chk("bp_hit",  32'(rsp_hit),   32'd1);
      chk("bp_idx",  32'(rsp_idx),   32'd2);
      chk("bp_rdy",  32'(req_ready), 32'd0);
    end
    // Release with req_valid still high: it must not be taken that cycle
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("bp_rel_vld", 32'(rsp_valid), 32'd0);
    chk("bp_rel_rdy", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("bp_idle_rdy", 32'(req_ready), 32'd1);

    // Write to a not-yet-scanned entry during SCAN cycle 2
    clear_table();
    chk("midwr_rdy", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = 4'h4;
    req_b     = 4'h5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    wr(3'd5, 4'h9);
    wait_rsp(3, cyc);
    chk("midwr_lat", 32'(cyc), EE ? 32'd7 : 32'(N + 1));
    chk("midwr_hit", 32'(rsp_hit), 32'd1);
    chk("midwr_idx", 32'(rsp_idx), 32'd5);
    finish_rsp("midwr");

    // Reset during SCAN cycle 3 aborts the lookup and invalidates entries
    wr(3'd0, 4'h9);
    req_valid = 1'b1;
    req_a     = 4'h4;
    req_b     = 4'h5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdy0", 32'(req_ready), 32'd0);
    chk("abort_vld",  32'(rsp_valid), 32'd0);
    chk("abort_hit",  32'(rsp_hit),   32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    chk("abort_rdy1",   32'(req_ready), 32'd1);
    lookup("post_abort", 4'h4, 4'h5, 1'b0, 3'd0, N + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
